// File: rtl/risc_pkg.sv
// risc_pkg: shared funct3 codes, exception causes, LSU state encoding and legality check
package risc_pkg;
  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;
  localparam logic [2:0] SB = 3'b000, SH = 3'b001, SW = 3'b010;
  localparam logic [1:0] EXC_NONE = 2'b00, EXC_MISALIGN = 2'b01, EXC_TIMEOUT = 2'b10, EXC_ILLEGAL = 2'b11;
  localparam logic [2:0] S_IDLE = 3'd0, S_REQ = 3'd1, S_WAIT = 3'd2, S_RESP = 3'd3, S_EXC = 3'd4;
  function automatic logic [1:0] lsu_check(input logic st, input logic [2:0] f3, input logic [1:0] a);
    logic legal;
    legal = st ? (f3 == SB || f3 == SH || f3 == SW)
               : (f3 == LB || f3 == LH || f3 == LW || f3 == LBU || f3 == LHU);
    return !legal ? EXC_ILLEGAL
         : (f3[1:0] == 2'b01 && a[0]) || (f3[1:0] == 2'b10 && a != 2'b00) ? EXC_MISALIGN
         : EXC_NONE;
  endfunction
endpackage

// File: rtl/risc_lsu_align.sv
// risc_lsu_align: store lane replication/strobes and load lane select/extension (funct3_i, addr_lo_i, wdata_i, rdata_i -> wdata_o, wstrb_o, ldata_o)
module risc_lsu_align
  import risc_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] wdata_o,
  output logic [3:0]  wstrb_o,
  output logic [31:0] ldata_o
);
  logic [31:0] sh;
  logic [7:0]  b;
  logic [15:0] h;
  logic        u;
  always_comb begin
    u       = funct3_i[2];
    sh      = rdata_i >> {addr_lo_i, 3'b000};
    b       = sh[7:0];
    h       = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    wdata_o = funct3_i[1:0] == 2'b00 ? {4{wdata_i[7:0]}}
            : funct3_i[1:0] == 2'b01 ? {2{wdata_i[15:0]}} : wdata_i;
    wstrb_o = funct3_i[1:0] == 2'b00 ? 4'b0001 << addr_lo_i
            : funct3_i[1:0] == 2'b01 ? (addr_lo_i[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    ldata_o = funct3_i[1:0] == 2'b00 ? {{24{~u & b[7]}}, b}
            : funct3_i[1:0] == 2'b01 ? {{16{~u & h[15]}}, h} : rdata_i;
  end
endmodule

// File: rtl/risc_lsu_32.sv
// risc_lsu_32: blocking load/store unit (ex_* request in, mem_* req/gnt/rvalid bus, wb_* writeback pulse, exc_* exception pulse)
module risc_lsu_32
  import risc_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic        ex_is_store,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  input  logic [4:0]  ex_rd,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic        wb_wen,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        exc_valid,
  output logic [1:0]  exc_cause,
  output logic [31:0] exc_addr
);
  localparam logic [15:0] TLAST = 16'(TIMEOUT_CYCLES - 1);
  logic [2:0]  state_q, state_d, f3_q;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  cause_q, cause_d, chk;
  logic [31:0] addr_q, wdata_q, rdata_q, rdata_d, rep, ldata;
  logic [4:0]  rd_q;
  logic        st_q, accept;
  logic [3:0]  strb;
  risc_lsu_align u_align (
    .funct3_i (f3_q),
    .addr_lo_i(addr_q[1:0]),
    .wdata_i  (wdata_q),
    .rdata_i  (mem_rdata),
    .wdata_o  (rep),
    .wstrb_o  (strb),
    .ldata_o  (ldata)
  );
  assign accept = state_q == S_IDLE && ex_valid;
  assign chk    = lsu_check(ex_is_store, ex_funct3, ex_addr[1:0]);
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cause_d = cause_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: if (ex_valid) begin
        cnt_d   = '0;
        cause_d = chk;
        state_d = chk != EXC_NONE ? S_EXC : S_REQ;
      end
      S_REQ, S_WAIT: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == TLAST) begin
          cause_d = EXC_TIMEOUT;
          state_d = S_EXC;
        end else if (state_q == S_REQ && mem_gnt) begin
          state_d = S_WAIT;
        end else if (state_q == S_WAIT && mem_rvalid) begin
          state_d = S_RESP;
          rdata_d = st_q ? '0 : ldata;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      cause_q <= EXC_NONE;
      rdata_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
      rd_q    <= '0;
      st_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
      rdata_q <= rdata_d;
      if (accept) begin
        addr_q  <= ex_addr;
        wdata_q <= ex_wdata;
        f3_q    <= ex_funct3;
        rd_q    <= ex_rd;
        st_q    <= ex_is_store;
      end
    end
  end
  assign ex_ready  = state_q == S_IDLE;
  assign mem_req   = state_q == S_REQ;
  assign mem_we    = mem_req & st_q;
  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign mem_wdata = rep;
  assign mem_wstrb = mem_we ? strb : 4'b0000;
  assign wb_valid  = state_q == S_RESP;
  assign wb_wen    = wb_valid & ~st_q & (rd_q != 5'd0);
  assign wb_rd     = rd_q;
  assign wb_data   = wb_valid ? rdata_q : '0;
  assign exc_valid = state_q == S_EXC;
  assign exc_cause = exc_valid ? cause_q : EXC_NONE;
  assign exc_addr  = exc_valid ? addr_q : '0;
endmodule

// File: tb/tb_risc_lsu_32.sv
// tb_risc_lsu_32: table-driven check of risc_lsu_32 plus timeout, stray-rvalid and mid-transaction reset sequences
module tb_risc_lsu_32;
  logic        clk = 1'b0, rst = 1'b1;
  logic        ex_valid = 1'b0, ex_ready, ex_is_store = 1'b0;
  logic [2:0]  ex_funct3 = '0;
  logic [31:0] ex_addr = '0, ex_wdata = '0;
  logic [4:0]  ex_rd = '0;
  logic        mem_req, mem_we, mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = '0;
  logic [3:0]  mem_wstrb;
  logic        wb_valid, wb_wen, exc_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data, exc_addr;
  logic [1:0]  exc_cause;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  risc_lsu_32 #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_is_store(ex_is_store),
    .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_rd(ex_rd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_data(wb_data),
    .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_addr(exc_addr)
  );
  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr, wdata;
    logic [4:0]  rd;
    logic [31:0] rdata;
    int          gw, rw;
    logic [1:0]  exc;
    logic [31:0] maddr, mwdata;
    logic [3:0]  strb;
    logic [31:0] wbd;
    logic        wen;
  } vec_t;
  vec_t v[13];
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", n, a, e);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd);
    ex_valid = 1'b1; ex_is_store = st; ex_funct3 = f3; ex_addr = a; ex_wdata = wd; ex_rd = rd;
    step();
    ex_valid = 1'b0;
  endtask
  task automatic run_vec(input vec_t x, input int i);
    string p;
    p = $sformatf("v%0d", i);
    issue(x.st, x.f3, x.addr, x.wdata, x.rd);
    if (x.exc != 2'b00) begin
      chk({p, "_exc_valid"}, 32'(exc_valid), 32'd1);
      chk({p, "_exc_cause"}, 32'(exc_cause), 32'(x.exc));
      chk({p, "_exc_addr"}, exc_addr, x.addr);
      chk({p, "_no_req"}, 32'(mem_req), 32'd0);
      step();
      chk({p, "_exc_pulse"}, 32'(exc_valid), 32'd0);
      chk({p, "_ready"}, 32'(ex_ready), 32'd1);
    end else begin
      chk({p, "_busy"}, 32'(ex_ready), 32'd0);
      chk({p, "_req"}, 32'(mem_req), 32'd1);
      chk({p, "_maddr"}, mem_addr, x.maddr);
      chk({p, "_mwdata"}, mem_wdata, x.mwdata);
      chk({p, "_wstrb"}, 32'(mem_wstrb), 32'(x.strb));
      chk({p, "_we"}, 32'(mem_we), 32'(x.st));
      for (int k = 0; k < x.gw; k++) begin
        step();
        chk({p, "_req_hold"}, 32'(mem_req), 32'd1);
      end
      mem_gnt = 1'b1;
      step();
      mem_gnt = 1'b0;
      chk({p, "_req_drop"}, 32'(mem_req), 32'd0);
      for (int k = 0; k < x.rw; k++) begin
        step();
        chk({p, "_wb_early"}, 32'(wb_valid), 32'd0);
      end
      mem_rvalid = 1'b1; mem_rdata = x.rdata;
      step();
      mem_rvalid = 1'b0;
      chk({p, "_wb_valid"}, 32'(wb_valid), 32'd1);
      chk({p, "_wb_data"}, wb_data, x.wbd);
      chk({p, "_wb_wen"}, 32'(wb_wen), 32'(x.wen));
      chk({p, "_wb_rd"}, 32'(wb_rd), 32'(x.rd));
      step();
      chk({p, "_wb_pulse"}, 32'(wb_valid), 32'd0);
      chk({p, "_idle"}, 32'(ex_ready), 32'd1);
    end
  endtask
  initial begin
    int nreq;
    logic got;
    v[0]  = '{1'b0, 3'b010, 32'h1004, 32'h0, 5'd5, 32'hDEADBEEF, 0, 0, 2'b00, 32'h1004, 32'h0, 4'h0, 32'hDEADBEEF, 1'b1};
    v[1]  = '{1'b0, 3'b000, 32'h1003, 32'h0, 5'd7, 32'h80FF0000, 0, 0, 2'b00, 32'h1000, 32'h0, 4'h0, 32'hFFFFFF80, 1'b1};
    v[2]  = '{1'b0, 3'b100, 32'h1003, 32'h0, 5'd7, 32'h80FF0000, 0, 0, 2'b00, 32'h1000, 32'h0, 4'h0, 32'h00000080, 1'b1};
    v[3]  = '{1'b0, 3'b001, 32'h1002, 32'h0, 5'd1, 32'h80FF0000, 0, 0, 2'b00, 32'h1000, 32'h0, 4'h0, 32'hFFFF80FF, 1'b1};
    v[4]  = '{1'b0, 3'b101, 32'h1000, 32'h0, 5'd0, 32'h12348001, 0, 0, 2'b00, 32'h1000, 32'h0, 4'h0, 32'h00008001, 1'b0};
    v[5]  = '{1'b1, 3'b001, 32'h2002, 32'h0000ABCD, 5'd3, 32'h0, 0, 0, 2'b00, 32'h2000, 32'hABCDABCD, 4'b1100, 32'h0, 1'b0};
    v[6]  = '{1'b1, 3'b000, 32'h3001, 32'h123456EF, 5'd4, 32'h0, 0, 0, 2'b00, 32'h3000, 32'hEFEFEFEF, 4'b0010, 32'h0, 1'b0};
    v[7]  = '{1'b1, 3'b010, 32'h4000, 32'hCAFEF00D, 5'd9, 32'h55555555, 1, 0, 2'b00, 32'h4000, 32'hCAFEF00D, 4'b1111, 32'h0, 1'b0};
    v[8]  = '{1'b0, 3'b010, 32'h1002, 32'h0, 5'd2, 32'h0, 0, 0, 2'b01, 32'h0, 32'h0, 4'h0, 32'h0, 1'b0};
    v[9]  = '{1'b0, 3'b011, 32'h1000, 32'h0, 5'd2, 32'h0, 0, 0, 2'b11, 32'h0, 32'h0, 4'h0, 32'h0, 1'b0};
    v[10] = '{1'b1, 3'b100, 32'h1001, 32'h0, 5'd2, 32'h0, 0, 0, 2'b11, 32'h0, 32'h0, 4'h0, 32'h0, 1'b0};
    v[11] = '{1'b1, 3'b001, 32'h2001, 32'h0, 5'd2, 32'h0, 0, 0, 2'b01, 32'h0, 32'h0, 4'h0, 32'h0, 1'b0};
    v[12] = '{1'b0, 3'b000, 32'h1001, 32'h0, 5'd6, 32'h00007F00, 0, 1, 2'b00, 32'h1000, 32'h0, 4'h0, 32'h0000007F, 1'b1};
    step();
    step();
    rst = 1'b0;
    step();
    chk("rst_ready", 32'(ex_ready), 32'd1);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_wb", 32'(wb_valid), 32'd0);
    chk("rst_exc", 32'(exc_valid), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    foreach (v[i]) run_vec(v[i], i);
    issue(1'b0, 3'b010, 32'h5000, 32'h0, 5'd8);
    nreq = 0;
    got = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (exc_valid) begin
        got = 1'b1;
        break;
      end
      if (mem_req) nreq++;
      step();
    end
    chk("to_seen", 32'(got), 32'd1);
    chk("to_req_cycles", nreq, 32'd4);
    chk("to_cause", 32'(exc_cause), 32'd2);
    chk("to_addr", exc_addr, 32'h5000);
    step();
    mem_rvalid = 1'b1; mem_rdata = 32'h11111111;
    step();
    mem_rvalid = 1'b0;
    chk("stray_wb0", 32'(wb_valid), 32'd0);
    step();
    chk("stray_wb1", 32'(wb_valid), 32'd0);
    run_vec(v[0], 100);
    issue(1'b0, 3'b010, 32'h6000, 32'h0, 5'd10);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst_req", 32'(mem_req), 32'd0);
    chk("mrst_wb", 32'(wb_valid), 32'd0);
    chk("mrst_exc", 32'(exc_valid), 32'd0);
    chk("mrst_ready", 32'(ex_ready), 32'd1);
    mem_rvalid = 1'b1; mem_rdata = 32'h22222222;
    step();
    mem_rvalid = 1'b0;
    chk("mrst_wb_late", 32'(wb_valid), 32'd0);
    chk("mrst_ready2", 32'(ex_ready), 32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/risc_lsu_32.md
Name: risc_lsu_32

Overview:
- Load/store unit directly downstream of the 32-bit ALU.
- Takes the ALU result as the effective address, plus store data, and runs one data-memory transaction per instruction over a req/gnt/rvalid bus.
- Aligns and sign/zero-extends load data, then presents the result to register-file writeback.
- Blocking, one transaction in flight; detects misalignment, illegal width and bus timeout.

Parameters:
- TIMEOUT_CYCLES, 255, cycles spent in REQ+WAIT before the transaction is aborted (1..65535).

Ports:
- clk  input  1  clock; all logic rising-edge.
- rst  input  1  reset: one clock; reset is synchronous and active-high.
- ex_valid  input  1  execute stage presents a memory instruction.
- ex_ready  output  1  LSU can accept; high only in IDLE.
- ex_is_store  input  1  1 = store, 0 = load.
- ex_funct3  input  3  RISC-V width/sign code.
- ex_addr  input  32  effective address (ALU output).
- ex_wdata  input  32  store data (rs2).
- ex_rd  input  5  load destination register.
- mem_req  output  1  bus request.
- mem_we  output  1  write enable.
- mem_addr  output  32  word address; bits[1:0] always 00.
- mem_wdata  output  32  store data replicated into lanes.
- mem_wstrb  output  4  byte strobes; 0000 for loads.
- mem_gnt  input  1  request accepted.
- mem_rvalid  input  1  response; read data for loads, ack for stores.
- mem_rdata  input  32  read data.
- wb_valid  output  1  one-cycle completion pulse.
- wb_wen  output  1  write register file (load and rd != 0).
- wb_rd  output  5  destination register.
- wb_data  output  32  extended load data; 0 for stores.
- exc_valid  output  1  one-cycle exception pulse.
- exc_cause  output  2  01 misaligned, 10 timeout, 11 illegal funct3.
- exc_addr  output  32  faulting ex_addr.

Behaviour:
- Reset: state IDLE, timeout counter 0. All outputs 0 except ex_ready = 1 in the cycle after reset releases. Reset mid-transaction aborts silently: no wb or exc pulse, mem_req drops next edge.
- States: IDLE, REQ, WAIT, RESP, EXC.
- Accept: in IDLE when ex_valid=1, latch addr, wdata, funct3, rd and is_store.
- Legality:
  - Legal load funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Legal store funct3: 000 SB, 001 SH, 010 SW.
  - Any other code goes to EXC, cause 11.
  - Alignment: half needs addr[0]=0; word needs addr[1:0]=00. Violation goes to EXC, cause 01.
  - Illegal funct3 takes priority over misalignment. No bus activity on either exception.
- Legal accept goes to REQ.
- REQ: mem_req=1 with stable addr/we/wdata/wstrb. When mem_gnt=1, go to WAIT; mem_req is 0 from the next cycle.
- WAIT: mem_rvalid=1 goes to RESP and captures mem_rdata. rvalid in the same cycle as gnt is not legal per bus protocol; the LSU is only required to sample rvalid in WAIT.
- RESP: wb_valid=1 for exactly one cycle, then IDLE.
- EXC: exc_valid=1 for exactly one cycle, then IDLE.
- Latency: accept at cycle N, mem_req at N+1. With gnt at G and rvalid at R>G, wb_valid is at R+1. Best case wb_valid at N+3.
- Load extraction:
  - Byte lane = addr[1:0]; half lane = addr[1].
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
  - LW passes data through.
- Store lanes:
  - SB replicates byte 4x, strobe = 0001 << addr[1:0].
  - SH replicates half 2x, strobe 0011 or 1100.
  - SW uses strobe 1111.
- Timeout:
  - Counter cleared on accept; increments each cycle in REQ or WAIT.
  - When it equals TIMEOUT_CYCLES: go to EXC, cause 10, mem_req drops.
  - A late rvalid arriving in IDLE is ignored.
- mem_rvalid/mem_gnt outside their states are ignored.
- wb_wen=0 for stores and for rd=0.

Decomposition:
- Shared package risc_pkg:
  - funct3 localparams: LB, LH, LW, LBU, LHU, SB, SH, SW.
  - exc_cause codes.
  - FSM state encoding (3-bit).
- One natural sub-module, risc_lsu_align: combinational store-lane replication/strobe generation and load lane-select/extension. FSM, counter and latches stay in the top.

Test Plan:
- LW, addr 0x0000_1004, rd=5; gnt 1 cycle after req, rvalid next cycle with 0xDEADBEEF -> mem_addr 0x1004, wstrb 0000, wb_valid at N+3, wb_data 0xDEADBEEF, wb_wen=1, wb_rd=5.
- LB addr 0x1003 and LBU addr 0x1003, rdata 0x80FF_0000 -> wb_data 0xFFFF_FF80 and 0x0000_0080 respectively.
- SH addr 0x2002, wdata 0x0000_ABCD -> mem_addr 0x2000, wdata 0xABCD_ABCD, wstrb 1100, we=1; wb_valid with wb_wen=0.
- LW addr 0x1002 -> no mem_req; exc_valid one cycle, cause 01, exc_addr 0x1002. Then funct3=011 load -> cause 11.
- TIMEOUT_CYCLES=4, gnt never asserted -> mem_req high exactly 4 cycles, exc cause 10. A later stray rvalid produces no wb_valid; next LW completes normally.
- Assert rst in WAIT -> no wb/exc pulse, mem_req 0, ex_ready=1 the cycle after reset releases.
